wb_slave: RTL and testbench
===========================

# wb_slave

Wishbone B4 classic-cycle slave with an internal register-file memory of 2^ADDR_WIDTH words of DATA_WIDTH bits. It handles one single read or single write per handshake and acknowledges each transfer with a registered `ack_o`. It is the reference endpoint for Wishbone master and interconnect bring-up.

## Interface
- `ADDR_WIDTH`, default 8: word-address width; memory depth = 2^ADDR_WIDTH words.
- `DATA_WIDTH`, default 32: data-bus and memory-word width.

Ports (one clock; reset is asynchronous and active-low):
- `clk_i`  in  1  system clock; all state changes on the rising edge.
- `rst_i`  in  1  asynchronous, active-low reset.
- `adr_i`  in  ADDR_WIDTH  word address of the transfer.
- `dat_i`  in  DATA_WIDTH  write data from the master.
- `dat_o`  out  DATA_WIDTH  read data to the master.
- `we_i`  in  1  transfer type: 1 = write, 0 = read.
- `cyc_i`  in  1  bus cycle in progress.
- `stb_i`  in  1  strobe; a valid transfer is `cyc_i & stb_i`.
- `ack_o`  out  1  transfer acknowledge.

## Operation
- **Storage:** `mem[0 .. 2^ADDR_WIDTH-1]`, each word DATA_WIDTH bits. No byte selects: whole-word access only.
- **Reset (`rst_i` = 0, asynchronous):**
  - every memory word is cleared to 0;
  - `dat_o` = 0, internal ack flag = 0, FSM = IDLE;
  - `ack_o` = 0 immediately, without waiting for a clock edge.
- **FSM states:** IDLE and ACK.
- **IDLE:**
  - At a rising edge with `cyc_i & stb_i` = 1, the transfer executes and the FSM moves to ACK.
  - Otherwise the FSM stays in IDLE.
- **Transfer execution at that same edge:**
  - `we_i` = 1: `mem[adr_i] <= dat_i`; `dat_o` keeps its previous value.
  - `we_i` = 0: `dat_o <= mem[adr_i]`; memory is unchanged.
- **ACK:** the internal ack flag is 1 for exactly one cycle. At the next rising edge the FSM returns to IDLE unconditionally and the flag clears.
- **`ack_o` gating:** `ack_o` = ack flag & `cyc_i` & `stb_i` (combinational gate). A master that drops `stb_i` or `cyc_i` while in ACK sees `ack_o` fall at once. The FSM still returns to IDLE at the next edge.
- **Committed writes:** a write is committed at the IDLE->ACK edge. Dropping `cyc_i` or `stb_i` afterwards does not undo it.
- **Held strobe:** if the master keeps `cyc_i & stb_i` high through ACK, no transfer is executed in the ACK cycle. A new transfer is sampled at the first IDLE edge, so back-to-back transfers are spaced 2 cycles apart.
- **`dat_o` validity:** `dat_o` is meaningful only while `ack_o` = 1 on a read. It holds its last value otherwise.
- **Address range:** `adr_i` always maps into memory, because depth is 2^ADDR_WIDTH. No address error is generated and no `err_o` exists.
- **Unknown inputs:** `we_i` and `adr_i` are sampled only at the IDLE edge with a valid strobe. X on them at other times has no effect.

## Timing
- **Latency:** the strobe is sampled at edge N, and `ack_o` is high from just after edge N until edge N+1 (one full cycle). Read data is valid on `dat_o` in the same window.
- **Throughput:** at most one transfer per 2 clock cycles.
- **Registered outputs:** `ack_o` and `dat_o` are registered; `ack_o` has only the combinational `cyc_i & stb_i` gate after its register. There is no combinational path from `adr_i` to `dat_o`.
- **Reset during ACK:** `ack_o` falls asynchronously, and the pending read data is discarded (`dat_o` = 0). A write sampled at the prior edge is also lost, because memory clears.
- **Reset release:** the FSM is in IDLE, and the first transfer can be sampled at the first rising edge after `rst_i` goes high.

## Test plan
- **Reset read:** reset, release, then read addr 0x00 -> `ack_o` high one cycle after the strobe is sampled, `dat_o` = 0x00000000.
- **Write/readback:** write 0xDEADBEEF to 0x05, then read 0x05 -> ack on each, read returns 0xDEADBEEF. Reading 0x04 and 0x06 returns 0.
- **Boundary addresses:** write 0x12345678 to 0xFF and 0xCAFEF00D to 0x00, then read both -> each returns its own value, with no aliasing.
- **Held strobe:** keep `cyc_i`/`stb_i` high through 3 reads of addresses 0x01, 0x02, 0x03 (changing `adr_i` right after each ack) -> `ack_o` pattern 1,0,1,0,1 per cycle, each with the correct data.
- **Abort:** assert the strobe, then drop `stb_i` during ACK -> `ack_o` falls immediately, the FSM is in IDLE at the next edge, and a subsequent write is acked normally.
- **Mid-transfer reset:** assert `rst_i` = 0 asynchronously while `ack_o` = 1 -> `ack_o` = 0 and `dat_o` = 0 without a clock edge. After release, all previously written words read 0.

Source files
------------

// File: rtl/wb_slave.sv
// Wishbone B4 classic-cycle slave backed by a 2^ADDR_WIDTH-word register file.
// One transfer per handshake, acknowledged by a registered, strobe-gated ack.
module wb_slave #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_WIDTH-1:0] adr_i,
    input  logic [DATA_WIDTH-1:0] dat_i,
    output logic [DATA_WIDTH-1:0] dat_o,
    input  logic                  we_i,
    input  logic                  cyc_i,
    input  logic                  stb_i,
    output logic                  ack_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_ACK  = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_stb;
    logic                  w_exec;
    logic                  r_ack;
    logic [DATA_WIDTH-1:0] r_dat;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    assign w_stb = cyc_i & stb_i;

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state; a transfer executes only on an IDLE edge with a valid strobe
    always_comb begin
        w_state_nxt = r_state;
        w_exec      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_stb) begin
                    w_exec      = 1'b1;
                    w_state_nxt = S_ACK;
                end
            end
            S_ACK: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Ack flag and read-data register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_ack <= 1'b0;
            r_dat <= '0;
        end else begin
            r_ack <= w_exec;
            if (w_exec && !we_i) begin
                r_dat <= r_mem[adr_i];
            end
        end
    end

    // Storage; whole array clears on reset so stale data never survives it
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_exec && we_i) begin
            r_mem[adr_i] <= dat_i;
        end
    end

    assign dat_o = r_dat;
    assign ack_o = r_ack & w_stb;

endmodule

// File: tb/tb_wb_slave.sv
// Self-checking bench for wb_slave: transaction-level model, per-cycle compare,
// directed test-plan scenarios and randomized traffic.
module tb_wb_slave;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 32;

    logic          clk_i;
    logic          rst_i;
    logic [AW-1:0] adr_i;
    logic [DW-1:0] dat_i;
    logic [DW-1:0] dat_o;
    logic          we_i;
    logic          cyc_i;
    logic          stb_i;
    logic          ack_o;

    int n_cmp;
    int n_err;
    bit run;

    wb_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .adr_i (adr_i),
        .dat_i (dat_i),
        .dat_o (dat_o),
        .we_i  (we_i),
        .cyc_i (cyc_i),
        .stb_i (stb_i),
        .ack_o (ack_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Transaction model: a slave that is either free or busy acknowledging
    logic [DW-1:0] m_mem [256];
    logic [DW-1:0] m_dat;
    bit            m_busy;

    initial begin
        for (int i = 0; i < 256; i++) m_mem[i] = '0;
        m_dat  = '0;
        m_busy = 1'b0;
    end

    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < 256; i++) m_mem[i] = '0;
            m_dat  = '0;
            m_busy = 1'b0;
        end else if (m_busy) begin
            m_busy = 1'b0;
        end else if (cyc_i && stb_i) begin
            if (we_i) m_mem[adr_i] = dat_i;
            else      m_dat = m_mem[adr_i];
            m_busy = 1'b1;
        end
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model
    always @(negedge clk_i) begin
        if (run) begin
            chk("model_ack", DW'(ack_o), DW'(m_busy && cyc_i && stb_i));
            chk("model_dat", dat_o, m_dat);
        end
    end

    // One handshake; returns read data seen while ack_o is high
    task automatic do_xfer(input bit we, input logic [AW-1:0] adr, input logic [DW-1:0] wd,
                           input bit hold, output logic [DW-1:0] rd);
        int cyc_cnt;
        bit got;
        @(negedge clk_i); #1;
        cyc_i = 1'b1; stb_i = 1'b1; we_i = we; adr_i = adr; dat_i = wd;
        cyc_cnt = 0;
        got = 1'b0;
        rd = '0;
        while (!got && cyc_cnt < 4) begin
            @(negedge clk_i);
            cyc_cnt++;
            if (ack_o) begin
                got = 1'b1;
                rd = dat_o;
            end
        end
        chk("ack_latency", DW'(cyc_cnt), DW'(got ? 1 : 99));
        if (hold) @(negedge clk_i);
        #1;
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'bx; adr_i = 'x; dat_i = 'x;
    endtask

    logic [DW-1:0] rd;
    logic [DW-1:0] exp_rd;
    logic [AW-1:0] ra;
    bit            rwe;

    initial begin
        n_cmp = 0; n_err = 0; run = 1'b0;
        rst_i = 1'b0; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        adr_i = '0; dat_i = '0;
        repeat (2) @(negedge clk_i);
        chk("reset_ack", DW'(ack_o), '0);
        chk("reset_dat", dat_o, '0);
        #1 rst_i = 1'b1;
        run = 1'b1;

        // Reset read
        do_xfer(1'b0, 8'h00, '0, 1'b0, rd);
        chk("reset_read", rd, 32'h0000_0000);

        // Write / readback with neighbours
        do_xfer(1'b1, 8'h05, 32'hDEAD_BEEF, 1'b0, rd);
        do_xfer(1'b0, 8'h05, '0, 1'b0, rd);
        chk("readback_05", rd, 32'hDEAD_BEEF);
        do_xfer(1'b0, 8'h04, '0, 1'b0, rd);
        chk("read_04", rd, 32'h0);
        do_xfer(1'b0, 8'h06, '0, 1'b0, rd);
        chk("read_06", rd, 32'h0);

        // Boundary addresses
        do_xfer(1'b1, 8'hFF, 32'h1234_5678, 1'b0, rd);
        do_xfer(1'b1, 8'h00, 32'hCAFE_F00D, 1'b0, rd);
        do_xfer(1'b0, 8'hFF, '0, 1'b0, rd);
        chk("read_FF", rd, 32'h1234_5678);
        do_xfer(1'b0, 8'h00, '0, 1'b0, rd);
        chk("read_00", rd, 32'hCAFE_F00D);

        // Held strobe through three reads
        do_xfer(1'b1, 8'h01, 32'h1111_0001, 1'b0, rd);
        do_xfer(1'b1, 8'h02, 32'h2222_0002, 1'b0, rd);
        do_xfer(1'b1, 8'h03, 32'h3333_0003, 1'b0, rd);
        @(negedge clk_i); #1;
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 8'h01;
        @(negedge clk_i);
        chk("held_ack0", DW'(ack_o), DW'(1));
        chk("held_dat1", dat_o, 32'h1111_0001);
        #1 adr_i = 8'h02;
        @(negedge clk_i);
        chk("held_ack1", DW'(ack_o), DW'(0));
        @(negedge clk_i);
        chk("held_ack2", DW'(ack_o), DW'(1));
        chk("held_dat2", dat_o, 32'h2222_0002);
        #1 adr_i = 8'h03;
        @(negedge clk_i);
        chk("held_ack3", DW'(ack_o), DW'(0));
        @(negedge clk_i);
        chk("held_ack4", DW'(ack_o), DW'(1));
        chk("held_dat3", dat_o, 32'h3333_0003);
        #1 cyc_i = 1'b0; stb_i = 1'b0;

        // Abort: drop strobe during ACK
        @(negedge clk_i); #1;
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 8'h05;
        @(negedge clk_i);
        chk("abort_ack_hi", DW'(ack_o), DW'(1));
        #1 stb_i = 1'b0;
        #1 chk("abort_ack_drop", DW'(ack_o), DW'(0));
        cyc_i = 1'b0;
        do_xfer(1'b1, 8'h07, 32'h0BAD_CAFE, 1'b0, rd);
        do_xfer(1'b0, 8'h07, '0, 1'b0, rd);
        chk("abort_then_write", rd, 32'h0BAD_CAFE);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            rwe = ($urandom_range(0, 2) == 0);
            ra  = ($urandom_range(0, 7) == 0) ? 8'hFF : AW'($urandom_range(0, 15));
            exp_rd = m_mem[ra];
            do_xfer(rwe, ra, $urandom, ($urandom_range(0, 3) == 0), rd);
            if (!rwe) chk("rand_read", rd, exp_rd);
            repeat ($urandom_range(0, 2)) @(negedge clk_i);
        end

        // Mid-transfer reset
        do_xfer(1'b1, 8'h09, 32'h5A5A_A5A5, 1'b0, rd);
        @(negedge clk_i); #1;
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 8'h09;
        @(negedge clk_i);
        chk("mid_ack_hi", DW'(ack_o), DW'(1));
        chk("mid_dat", dat_o, 32'h5A5A_A5A5);
        #2 rst_i = 1'b0;
        #1;
        chk("mid_rst_ack", DW'(ack_o), DW'(0));
        chk("mid_rst_dat", dat_o, DW'(0));
        cyc_i = 1'b0; stb_i = 1'b0;
        @(negedge clk_i); #1 rst_i = 1'b1;
        do_xfer(1'b0, 8'h09, '0, 1'b0, rd);
        chk("post_rst_09", rd, 32'h0);
        do_xfer(1'b0, 8'h05, '0, 1'b0, rd);
        chk("post_rst_05", rd, 32'h0);
        do_xfer(1'b0, 8'hFF, '0, 1'b0, rd);
        chk("post_rst_FF", rd, 32'h0);

        repeat (2) @(negedge clk_i);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
